vga_sprite_renderer: RTL and testbench

VGA_SPRITE_RENDERER -- requirements
Module: vga_sprite_renderer

---
 rtl/vga_pkg.sv | 14 +
 rtl/vga_bounce_axis.sv | 62 ++++++
 rtl/vga_sprite_renderer.sv | 105 ++++++++++
 tb/tb_vga_sprite_renderer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants and the bounce-axis state type.
package vga_pkg;

   localparam int SCREEN_WIDTH  = 640;
   localparam int SCREEN_HEIGHT = 480;
   localparam int RGB_W         = 12;

   // Syncs are active-low: asserted level and idle level.
   localparam logic SYNC_ACTIVE = 1'b0;
   localparam logic SYNC_IDLE   = 1'b1;

   typedef enum logic {INC, DEC} axis_state_t;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of sprite motion: steps by STEP on each update and reverses at 0 and LIM.
module vga_bounce_axis
   import vga_pkg::*;
#(
   parameter int LIM  = 608,
   parameter int STEP = 2,
   parameter int INIT = 0
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       update,
   output logic [9:0] pos,
   output logic       bounce
);

   axis_state_t state, state_next;
   logic [9:0]  pos_next;
   logic [10:0] sum;

   // Next position/direction; bounce is flagged only on an update that hits a wall.
   always_comb begin
      state_next = state;
      pos_next   = pos;
      bounce     = 1'b0;
      sum        = {1'b0, pos} + 11'(STEP);
      if (update) begin
         unique case (state)
            INC: begin
               if (sum >= 11'(LIM)) begin
                  pos_next   = 10'(LIM);
                  state_next = DEC;
                  bounce     = 1'b1;
               end else begin
                  pos_next = sum[9:0];
               end
            end
            DEC: begin
               if (pos <= 10'(STEP)) begin
                  pos_next   = '0;
                  state_next = INC;
                  bounce     = 1'b1;
               end else begin
                  pos_next = pos - 10'(STEP);
               end
            end
            default: ;
         endcase
      end
   end

   // State and position registers.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state <= INC;
         pos   <= 10'(INIT);
      end else begin
         state <= state_next;
         pos   <= pos_next;
      end
   end

endmodule

// File: rtl/vga_sprite_renderer.sv
// Bouncing square sprite over a flat background, two-stage registered pixel pipeline.
module vga_sprite_renderer
   import vga_pkg::*;
#(
   parameter int               BOX_SIZE  = 32,
   parameter int               STEP      = 2,
   parameter int               FRAME_DIV = 1,
   parameter logic [RGB_W-1:0] BOX_COLOR = 12'hF00,
   parameter logic [RGB_W-1:0] BG_COLOR  = 12'h00F,
   parameter int               X_INIT    = 304,
   parameter int               Y_INIT    = 224
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic [9:0]       hcount,
   input  logic [9:0]       vcount,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             display_in,
   input  logic             eof,
   input  logic             enable,
   output logic [RGB_W-1:0] rgb,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic             display_out,
   output logic [7:0]       bounce_count
);

   localparam int X_LIM = SCREEN_WIDTH - BOX_SIZE;
   localparam int Y_LIM = SCREEN_HEIGHT - BOX_SIZE;

   logic [7:0]  div_cnt;
   logic        div_wrap, update;
   logic [9:0]  x_pos, y_pos;
   logic        x_bounce, y_bounce;
   logic [10:0] x_end, y_end;
   logic        in_box;
   logic        box_q, disp_q, hs_q, vs_q;

   assign div_wrap = (div_cnt == 8'(FRAME_DIV - 1));
   assign update   = eof && enable && !rst && div_wrap;

   // Frame divider: counts enabled end-of-frame strobes.
   always_ff @(posedge pclk) begin
      if (rst)
         div_cnt <= '0;
      else if (eof && enable)
         div_cnt <= div_wrap ? '0 : div_cnt + 8'd1;
   end

   vga_bounce_axis #(.LIM(X_LIM), .STEP(STEP), .INIT(X_INIT)) x_axis (
      .pclk(pclk), .rst(rst), .update(update), .pos(x_pos), .bounce(x_bounce)
   );

   vga_bounce_axis #(.LIM(Y_LIM), .STEP(STEP), .INIT(Y_INIT)) y_axis (
      .pclk(pclk), .rst(rst), .update(update), .pos(y_pos), .bounce(y_bounce)
   );

   // Count updates with any wall hit; a corner hit counts once.
   always_ff @(posedge pclk) begin
      if (rst)
         bounce_count <= '0;
      else if (x_bounce || y_bounce)
         bounce_count <= bounce_count + 8'd1;
   end

   // Sprite hit test with 11-bit end coordinates so x+BOX_SIZE cannot wrap.
   always_comb begin
      x_end  = {1'b0, x_pos} + 11'(BOX_SIZE);
      y_end  = {1'b0, y_pos} + 11'(BOX_SIZE);
      in_box = (hcount >= x_pos) && ({1'b0, hcount} < x_end) &&
               (vcount >= y_pos) && ({1'b0, vcount} < y_end);
   end

   // Stage 1: hit flag plus delayed qualifier and syncs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         box_q  <= 1'b0;
         disp_q <= 1'b0;
         hs_q   <= SYNC_IDLE;
         vs_q   <= SYNC_IDLE;
      end else begin
         box_q  <= in_box;
         disp_q <= display_in;
         hs_q   <= hsync_in;
         vs_q   <= vsync_in;
      end
   end

   // Stage 2: colour select and aligned sync outputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         rgb         <= '0;
         display_out <= 1'b0;
         hsync_out   <= SYNC_IDLE;
         vsync_out   <= SYNC_IDLE;
      end else begin
         rgb         <= !disp_q ? '0 : (box_q ? BOX_COLOR : BG_COLOR);
         display_out <= disp_q;
         hsync_out   <= hs_q;
         vsync_out   <= vs_q;
      end
   end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// Self-checking bench: five renderer configurations driven in lockstep against a frame-level model.
module tb_vga_sprite_renderer;

   localparam int N = 5;

   logic pclk = 1'b0;
   logic rst, hsync_in, vsync_in, display_in, eof, enable;
   logic [9:0] hcount, vcount;
   logic [N-1:0][11:0] rgb_o;
   logic [N-1:0]       hs_o, vs_o, de_o;
   logic [N-1:0][7:0]  bc_o;

   always #5 pclk = ~pclk;

   vga_sprite_renderer dut0 (.pclk(pclk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .display_in(display_in), .eof(eof), .enable(enable),
      .rgb(rgb_o[0]), .hsync_out(hs_o[0]), .vsync_out(vs_o[0]), .display_out(de_o[0]), .bounce_count(bc_o[0]));
   vga_sprite_renderer #(.X_INIT(606)) dut1 (.pclk(pclk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .display_in(display_in), .eof(eof), .enable(enable),
      .rgb(rgb_o[1]), .hsync_out(hs_o[1]), .vsync_out(vs_o[1]), .display_out(de_o[1]), .bounce_count(bc_o[1]));
   vga_sprite_renderer #(.X_INIT(608), .Y_INIT(448)) dut2 (.pclk(pclk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .display_in(display_in), .eof(eof), .enable(enable),
      .rgb(rgb_o[2]), .hsync_out(hs_o[2]), .vsync_out(vs_o[2]), .display_out(de_o[2]), .bounce_count(bc_o[2]));
   vga_sprite_renderer #(.FRAME_DIV(3)) dut3 (.pclk(pclk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .display_in(display_in), .eof(eof), .enable(enable),
      .rgb(rgb_o[3]), .hsync_out(hs_o[3]), .vsync_out(vs_o[3]), .display_out(de_o[3]), .bounce_count(bc_o[3]));
   vga_sprite_renderer #(.BOX_SIZE(240), .STEP(240), .X_INIT(0), .Y_INIT(0),
                         .BOX_COLOR(12'h0F0), .BG_COLOR(12'h111)) dut4 (.pclk(pclk), .rst(rst),
      .hcount(hcount), .vcount(vcount), .hsync_in(hsync_in), .vsync_in(vsync_in), .display_in(display_in),
      .eof(eof), .enable(enable), .rgb(rgb_o[4]), .hsync_out(hs_o[4]), .vsync_out(vs_o[4]),
      .display_out(de_o[4]), .bounce_count(bc_o[4]));

   // Configuration of each instance, as the model sees it.
   int          p_bs  [N] = '{32, 32, 32, 32, 240};
   int          p_st  [N] = '{2, 2, 2, 2, 240};
   int          p_div [N] = '{1, 1, 1, 3, 1};
   int          p_x0  [N] = '{304, 606, 608, 304, 0};
   int          p_y0  [N] = '{224, 224, 448, 224, 0};
   logic [11:0] p_box [N] = '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'h0F0};
   logic [11:0] p_bg  [N] = '{12'h00F, 12'h00F, 12'h00F, 12'h00F, 12'h111};

   // Model state: sprite corner, direction (+1/-1), frame divider, bounce tally, and output history.
   int          mx[N], my[N], mdx[N], mdy[N], mdiv[N], mbc[N];
   logic [11:0] s1_rgb[N], s2_rgb[N];
   logic        s1_hs[N], s2_hs[N], s1_vs[N], s2_vs[N], s1_de[N], s2_de[N];

   int tests = 0;
   int fails = 0;

   task automatic axis_move(inout int pos, inout int dir, input int step, input int lim, output bit b);
      b = 1'b0;
      if (dir > 0) begin
         if (pos + step >= lim) begin pos = lim; dir = -1; b = 1'b1; end
         else pos = pos + step;
      end else begin
         if (pos <= step) begin pos = 0; dir = 1; b = 1'b1; end
         else pos = pos - step;
      end
   endtask

   // Drive one pixel-clock worth of synchronizer outputs, advance the model, sample #1 after the edge.
   task automatic cycle(input int h, input int v, input bit e, input bit en, input bit r);
      bit d, hs, vs, bx, by, inb;
      d  = (h < 640) && (v < 480);
      hs = !(h >= 656 && h < 752);
      vs = !(v >= 490 && v < 492);
      @(negedge pclk);
      hcount = 10'(h); vcount = 10'(v); display_in = d; hsync_in = hs; vsync_in = vs;
      eof = e; enable = en; rst = r;
      for (int i = 0; i < N; i++) begin
         if (r) begin
            mx[i] = p_x0[i]; my[i] = p_y0[i]; mdx[i] = 1; mdy[i] = 1; mdiv[i] = 0; mbc[i] = 0;
            s1_rgb[i] = '0; s2_rgb[i] = '0; s1_hs[i] = 1; s2_hs[i] = 1;
            s1_vs[i] = 1; s2_vs[i] = 1; s1_de[i] = 0; s2_de[i] = 0;
         end else begin
            s2_rgb[i] = s1_rgb[i]; s2_hs[i] = s1_hs[i]; s2_vs[i] = s1_vs[i]; s2_de[i] = s1_de[i];
            inb = (h >= mx[i]) && (h < mx[i] + p_bs[i]) && (v >= my[i]) && (v < my[i] + p_bs[i]);
            s1_rgb[i] = !d ? 12'h000 : (inb ? p_box[i] : p_bg[i]);
            s1_hs[i] = hs; s1_vs[i] = vs; s1_de[i] = d;
            if (e && en) begin
               if (mdiv[i] == p_div[i] - 1) begin
                  mdiv[i] = 0;
                  axis_move(mx[i], mdx[i], p_st[i], 640 - p_bs[i], bx);
                  axis_move(my[i], mdy[i], p_st[i], 480 - p_bs[i], by);
                  if (bx || by) mbc[i] = (mbc[i] + 1) % 256;
               end else begin
                  mdiv[i] = mdiv[i] + 1;
               end
            end
         end
      end
      @(posedge pclk);
      #1;
   endtask

   // Probe coordinates straddling the four edges of instance i's current sprite.
   function automatic int probe_h(input int i, input int k);
      int offs[4];
      int h;
      offs = '{-1, 0, p_bs[i] - 1, p_bs[i]};
      h = mx[i] + offs[k % 4];
      return (h < 0) ? 0 : (h > 799 ? 799 : h);
   endfunction

   function automatic int probe_v(input int i, input int k);
      int offs[4];
      int v;
      offs = '{-1, 0, p_bs[i] - 1, p_bs[i]};
      v = my[i] + offs[k / 4];
      return (v < 0) ? 0 : (v > 524 ? 524 : v);
   endfunction

   task automatic test_reset;
      for (int c = 0; c < 3; c++) begin
         cycle($urandom_range(799), $urandom_range(524), 1'b1, 1'b1, 1'b1);
         for (int i = 0; i < N; i++) begin
            tests++;
            if ({rgb_o[i], hs_o[i], vs_o[i], de_o[i], bc_o[i]} !== {12'h000, 1'b1, 1'b1, 1'b0, 8'h00}) begin
               fails++;
               $display("FAIL reset inst%0d: rgb=%h hs=%b vs=%b de=%b bc=%0d, want rgb=000 hs=1 vs=1 de=0 bc=0",
                        i, rgb_o[i], hs_o[i], vs_o[i], de_o[i], bc_o[i]);
            end
         end
      end
      // The first cycle after release still shows flushed pipeline values.
      cycle(310, 230, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) begin
         tests++;
         if ({rgb_o[i], hs_o[i], vs_o[i], de_o[i]} !== {12'h000, 1'b1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_flush inst%0d: rgb=%h hs=%b vs=%b de=%b, want 000 1 1 0",
                     i, rgb_o[i], hs_o[i], vs_o[i], de_o[i]);
         end
      end
   endtask

   task automatic test_render(input bit en);
      for (int i = 0; i < N; i++)
         for (int k = 0; k < 16; k++) begin
            cycle(probe_h(i, k), probe_v(i, k), 1'b0, en, 1'b0);
            for (int j = 0; j < N; j++) begin
               tests++;
               if (rgb_o[j] !== s2_rgb[j] || de_o[j] !== s2_de[j]) begin
                  fails++;
                  $display("FAIL render_edge inst%0d: rgb=%h de=%b, want rgb=%h de=%b",
                           j, rgb_o[j], de_o[j], s2_rgb[j], s2_de[j]);
               end
            end
         end
      for (int c = 0; c < 200; c++) begin
         if (c % 2 == 0)
            cycle($urandom_range(799), $urandom_range(524), 1'b0, en, 1'b0);
         else
            cycle(mx[0] - 8 + $urandom_range(48), my[0] - 8 + $urandom_range(48), 1'b0, en, 1'b0);
         for (int j = 0; j < N; j++) begin
            tests++;
            if (rgb_o[j] !== s2_rgb[j]) begin
               fails++;
               $display("FAIL render_rand inst%0d: rgb=%h, want %h", j, rgb_o[j], s2_rgb[j]);
            end
         end
      end
   endtask

   task automatic test_sync;
      for (int h = 630; h < 800; h++) begin
         cycle(h, 100, 1'b0, 1'b1, 1'b0);
         tests++;
         if (hs_o[0] !== s2_hs[0] || de_o[0] !== s2_de[0] || rgb_o[0] !== s2_rgb[0]) begin
            fails++;
            $display("FAIL hsync h=%0d: hs=%b de=%b rgb=%h, want hs=%b de=%b rgb=%h",
                     h, hs_o[0], de_o[0], rgb_o[0], s2_hs[0], s2_de[0], s2_rgb[0]);
         end
      end
      for (int v = 470; v < 525; v++) begin
         cycle(700, v, 1'b0, 1'b1, 1'b0);
         tests++;
         if (vs_o[0] !== s2_vs[0] || hs_o[0] !== s2_hs[0]) begin
            fails++;
            $display("FAIL vsync v=%0d: vs=%b hs=%b, want vs=%b hs=%b", v, vs_o[0], hs_o[0], s2_vs[0], s2_hs[0]);
         end
      end
   endtask

   task automatic test_motion;
      int          hh[7] = '{305, 306, 337, 338, 306, 306, 0};
      int          vv[7] = '{226, 226, 257, 257, 225, 258, 0};
      logic [11:0] ex[6] = '{12'h00F, 12'hF00, 12'hF00, 12'h00F, 12'h00F, 12'h00F};
      logic [7:0]  bc1[N] = '{8'd0, 8'd1, 8'd1, 8'd0, 8'd1};
      cycle(640, 480, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) begin
         tests++;
         if (bc_o[i] !== bc1[i]) begin
            fails++;
            $display("FAIL first_update_bounce inst%0d: bc=%0d, want %0d", i, bc_o[i], bc1[i]);
         end
      end
      // Default sprite must now sit at (306,226).
      for (int k = 0; k < 7; k++) begin
         cycle(hh[k], vv[k], 1'b0, 1'b1, 1'b0);
         if (k > 0) begin
            tests++;
            if (rgb_o[0] !== ex[k-1]) begin
               fails++;
               $display("FAIL moved_edge (%0d,%0d): rgb=%h, want %h", hh[k-1], vv[k-1], rgb_o[0], ex[k-1]);
            end
         end
      end
      for (int f = 0; f < 4; f++) begin
         cycle(640, 480, 1'b1, 1'b1, 1'b0);
         for (int j = 0; j < N; j++) begin
            tests++;
            if (bc_o[j] !== 8'(mbc[j])) begin
               fails++;
               $display("FAIL motion_bounce inst%0d frame%0d: bc=%0d, want %0d", j, f, bc_o[j], mbc[j]);
            end
         end
         test_render(1'b1);
      end
   endtask

   task automatic test_enable;
      for (int f = 0; f < 2; f++) begin
         cycle(640, 480, 1'b1, 1'b0, 1'b0);
         test_render(1'b0);
      end
      for (int f = 0; f < 3; f++) begin
         cycle(640, 480, 1'b1, 1'b1, 1'b0);
         for (int j = 0; j < N; j++) begin
            tests++;
            if (bc_o[j] !== 8'(mbc[j])) begin
               fails++;
               $display("FAIL enable_bounce inst%0d: bc=%0d, want %0d", j, bc_o[j], mbc[j]);
            end
         end
         test_render(1'b1);
      end
   endtask

   task automatic test_mid_reset;
      cycle(318, 240, 1'b0, 1'b1, 1'b0);
      cycle(319, 240, 1'b0, 1'b1, 1'b0);
      cycle(320, 240, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < N; i++) begin
         tests++;
         if ({rgb_o[i], hs_o[i], vs_o[i], de_o[i], bc_o[i]} !== {12'h000, 1'b1, 1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL mid_reset inst%0d: rgb=%h hs=%b vs=%b de=%b bc=%0d, want 000 1 1 0 0",
                     i, rgb_o[i], hs_o[i], vs_o[i], de_o[i], bc_o[i]);
         end
      end
      // An end-of-frame strobe under reset must not move anything.
      cycle(640, 480, 1'b1, 1'b1, 1'b1);
      test_render(1'b1);
   endtask

   task automatic test_back_to_back;
      for (int c = 0; c < 300; c++) begin
         cycle(640, 480, 1'b1, 1'b1, 1'b0);
         for (int j = 0; j < N; j++) begin
            tests++;
            if (bc_o[j] !== 8'(mbc[j])) begin
               fails++;
               $display("FAIL b2b_bounce inst%0d upd%0d: bc=%0d, want %0d", j, c, bc_o[j], mbc[j]);
            end
         end
      end
      test_render(1'b1);
   endtask

   initial begin
      rst = 1'b1; eof = 1'b0; enable = 1'b0; hcount = '0; vcount = '0;
      hsync_in = 1'b1; vsync_in = 1'b1; display_in = 1'b0;
      test_reset();
      test_render(1'b1);
      test_sync();
      test_motion();
      test_enable();
      test_mid_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
